// File: rtl/burst_ram_arbiter_pkg.sv
// Shared definitions for the burst RAM line arbiter: parameter defaults and
// the sequencing FSM state encoding.
package burst_ram_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH  = 21;
  localparam int DEF_BEAT_WIDTH  = 64;
  localparam int DEF_BURST_BEATS = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // A one-beat burst still needs a 1-bit counter to keep the vectors legal.
  function automatic int beat_cnt_bits(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one burst RAM command port between a fetch and a
// data line requester; serialises write lines and assembles read lines.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a request while the controller is not busy
// S_ISSUE | command strobe; write beat 0 is driven in the same cycle
// S_WRITE | driving write beats 1..BURST_BEATS-1 back to back
// S_READ  | collecting read beats into the line buffer, no timeout
// S_DONE  | done pulse to the granted port, round-robin pointer updated
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
#(
  parameter int  ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int  BEAT_WIDTH  = DEF_BEAT_WIDTH,
  parameter int  BURST_BEATS = DEF_BURST_BEATS,
  localparam int LINE_WIDTH  = BEAT_WIDTH * BURST_BEATS
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [LINE_WIDTH-1:0]   p0_wdata,
  output logic [LINE_WIDTH-1:0]   p0_rdata,
  output logic                    p0_done,

  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [LINE_WIDTH-1:0]   p1_wdata,
  output logic [LINE_WIDTH-1:0]   p1_rdata,
  output logic                    p1_done,

  output logic                    br_cmd,
  output logic                    br_cmd_en,
  output logic [ADDR_WIDTH-1:0]   br_addr,
  output logic [BEAT_WIDTH-1:0]   br_wr_data,
  output logic [BEAT_WIDTH/8-1:0] br_wr_mask,
  input  logic [BEAT_WIDTH-1:0]   br_rd_data,
  input  logic                    br_rd_data_valid,
  input  logic                    br_busy
);

  localparam int CW       = beat_cnt_bits(BURST_BEATS);
  localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [CW-1:0]         LAST_BEAT = CW'(BURST_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_BITS;

  state_t                  state_q, state_d;
  logic                    take;
  logic                    sel;
  logic                    grant_q;
  logic                    rr_last_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [CW-1:0]           cnt_q;
  logic [LINE_WIDTH-1:0]   rbuf_q, rbuf_next;
  logic [LINE_WIDTH-1:0]   p0_rdata_q, p1_rdata_q;
  logic                    beat_last;

  assign beat_last = (cnt_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    sel     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!br_busy && (p0_req || p1_req)) begin
          take    = 1'b1;
          // On a tie the port that was not served last wins.
          sel     = (p0_req && p1_req) ? ~rr_last_q : p1_req;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!we_q)                 state_d = S_READ;
        else if (BURST_BEATS == 1) state_d = S_DONE;
        else                       state_d = S_WRITE;
      end
      S_WRITE: if (beat_last) state_d = S_DONE;
      S_READ:  if (br_rd_data_valid && beat_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rbuf_next = rbuf_q;
    rbuf_next[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] = br_rd_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q    <= 1'b0;
      rr_last_q  <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rbuf_q     <= '0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      if (take) begin
        grant_q <= sel;
        we_q    <= sel ? p1_we : p0_we;
        addr_q  <= (sel ? p1_addr : p0_addr) & LINE_MASK;
        wdata_q <= sel ? p1_wdata : p0_wdata;
        cnt_q   <= '0;
      end
      if ((state_q == S_ISSUE && we_q) || state_q == S_WRITE)
        cnt_q <= cnt_q + CW'(1);
      if (state_q == S_READ && br_rd_data_valid) begin
        cnt_q  <= cnt_q + CW'(1);
        rbuf_q <= rbuf_next;
        // Requester-visible line only changes once the whole burst is in.
        if (beat_last) begin
          if (grant_q) p1_rdata_q <= rbuf_next;
          else         p0_rdata_q <= rbuf_next;
        end
      end
      if (state_q == S_DONE) rr_last_q <= grant_q;
    end
  end

  always_comb begin
    br_wr_data = '0;
    if ((state_q == S_ISSUE && we_q) || state_q == S_WRITE)
      br_wr_data = wdata_q[int'(cnt_q) * BEAT_WIDTH +: BEAT_WIDTH];
  end

  assign br_cmd_en  = (state_q == S_ISSUE);
  assign br_cmd     = br_cmd_en & we_q;
  assign br_addr    = br_cmd_en ? addr_q : '0;
  assign br_wr_mask = '0;

  assign p0_done  = (state_q == S_DONE) && !grant_q;
  assign p1_done  = (state_q == S_DONE) &&  grant_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule
